// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX path: stream beat layout, arbiter
// state encoding and default inter-frame gap.
package eth_pkg;

  localparam int BEAT_DATA_LSB = 0;
  localparam int BEAT_VLD_BIT  = 8;
  localparam int BEAT_SOF_BIT  = 9;
  localparam int BEAT_EOF_BIT  = 10;
  localparam int BEAT_W        = 11;

  localparam int IFG_CYC_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Combinational round-robin search: first requester after 'last', with wrap.
module rr_pick
  import eth_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IW    = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IW'((32'(last) + k) % N_SRC);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter feeding one TX chain from N_SRC byte streams,
// with programmable inter-frame gap, per-source frame counters and error flags.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int IFG_CYC = IFG_CYC_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC-1:0]       in_sof,
  input  logic [N_SRC-1:0]       in_vld,
  input  logic [8*N_SRC-1:0]     in_data,
  input  logic [N_SRC-1:0]       in_eof,
  output logic [N_SRC-1:0]       in_rdy,
  output logic                   out_sof,
  output logic                   out_vld,
  output logic [7:0]             out_data,
  output logic                   out_eof,
  input  logic                   out_rdy,
  output logic [N_SRC-1:0]       grant,
  output logic                   busy,
  output logic [N_SRC-1:0]       err_pulse,
  output logic [CNT_W*N_SRC-1:0] frm_cnt
);

  localparam int IW = idx_w(N_SRC);
  localparam int GW = idx_w((IFG_CYC > 1) ? IFG_CYC : 2);
  localparam logic [GW-1:0] GAP_LOAD = (IFG_CYC > 0) ? GW'(IFG_CYC - 1) : '0;

  arb_state_t       state;
  logic [IW-1:0]    last;
  logic [GW-1:0]    gap_cnt;
  logic             first_beat;
  logic [CNT_W-1:0] cnt_q [N_SRC];

  logic [N_SRC-1:0]  req;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [BEAT_W-1:0] sel_beat;
  logic              xfer_beat;

  assign req = in_vld & in_sof & src_en;

  rr_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // 'last' doubles as the index of the current owner while in XFER.
  always_comb begin
    sel_beat = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (IW'(i) == last) begin
        sel_beat[BEAT_DATA_LSB +: 8] = in_data[8*i +: 8];
        sel_beat[BEAT_VLD_BIT]       = in_vld[i];
        sel_beat[BEAT_SOF_BIT]       = in_sof[i];
        sel_beat[BEAT_EOF_BIT]       = in_eof[i];
      end
    end
  end

  assign xfer_beat = (state == ST_XFER) && sel_beat[BEAT_VLD_BIT] && out_rdy;

  always_comb begin
    in_rdy   = '0;
    out_sof  = 1'b0;
    out_vld  = 1'b0;
    out_data = '0;
    out_eof  = 1'b0;
    case (state)
      ST_IDLE: in_rdy = in_vld & ~in_sof;
      ST_XFER: begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
          if (IW'(i) == last) in_rdy[i] = out_rdy;
        end
        out_vld  = sel_beat[BEAT_VLD_BIT];
        out_sof  = sel_beat[BEAT_SOF_BIT] & first_beat;
        out_eof  = sel_beat[BEAT_EOF_BIT];
        out_data = sel_beat[BEAT_DATA_LSB +: 8];
      end
      default: ;
    endcase
    // Orphan discard must not swallow bytes while reset is held.
    if (rest) in_rdy = '0;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last       <= IW'(N_SRC - 1);
      gap_cnt    <= '0;
      first_beat <= 1'b0;
      busy       <= 1'b0;
      err_pulse  <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
    end else begin
      err_pulse <= '0;
      case (state)
        ST_IDLE: begin
          err_pulse <= in_vld & ~in_sof;
          if (pick_found) begin
            grant      <= N_SRC'(1) << pick_idx;
            last       <= pick_idx;
            first_beat <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_beat) begin
            first_beat <= 1'b0;
            if (sel_beat[BEAT_SOF_BIT] && !first_beat)
              err_pulse <= N_SRC'(1) << last;
            if (sel_beat[BEAT_EOF_BIT]) begin
              for (int unsigned i = 0; i < N_SRC; i++) begin
                if (IW'(i) == last && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
              end
              grant <= '0;
              if (IFG_CYC == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt
    assign frm_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed self-checking bench for eth_tx_arb (2 sources, IFG 12) plus a
// narrow-counter, zero-gap instance for saturation and back-to-back single bytes.
module tb_eth_tx_arb;

  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rest;
  logic [1:0]  src_en, in_sof, in_vld, in_eof, in_rdy;
  logic [15:0] in_data;
  logic        out_sof, out_vld, out_eof, out_rdy, busy;
  logic [7:0]  out_data;
  logic [1:0]  grant, err_pulse;
  logic [31:0] frm_cnt;

  logic [1:0]  s_src_en, s_in_sof, s_in_vld, s_in_eof, s_in_rdy, s_grant, s_err_pulse;
  logic [15:0] s_in_data;
  logic        s_out_sof, s_out_vld, s_out_eof, s_out_rdy, s_busy;
  logic [7:0]  s_out_data;
  logic [5:0]  s_frm_cnt;

  always #4 clk = ~clk;

  eth_tx_arb #(.N_SRC(2), .IFG_CYC(IFG), .CNT_W(16)) dut (
    .clk(clk), .rest(rest), .src_en(src_en), .in_sof(in_sof), .in_vld(in_vld),
    .in_data(in_data), .in_eof(in_eof), .in_rdy(in_rdy), .out_sof(out_sof),
    .out_vld(out_vld), .out_data(out_data), .out_eof(out_eof), .out_rdy(out_rdy),
    .grant(grant), .busy(busy), .err_pulse(err_pulse), .frm_cnt(frm_cnt)
  );

  eth_tx_arb #(.N_SRC(2), .IFG_CYC(0), .CNT_W(3)) u_sat (
    .clk(clk), .rest(rest), .src_en(s_src_en), .in_sof(s_in_sof), .in_vld(s_in_vld),
    .in_data(s_in_data), .in_eof(s_in_eof), .in_rdy(s_in_rdy), .out_sof(s_out_sof),
    .out_vld(s_out_vld), .out_data(s_out_data), .out_eof(s_out_eof), .out_rdy(s_out_rdy),
    .grant(s_grant), .busy(s_busy), .err_pulse(s_err_pulse), .frm_cnt(s_frm_cnt)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  int nvec = 0;
  int nfail = 0;
  int len [2];
  int ptr [2];
  int frames_left [2];
  int dup_sof_pos [2];
  int rdy_bad;
  beat_t      obs [$];
  logic [1:0] g_hist [$];
  logic       b_hist [$];
  logic [1:0] e_hist [$];
  logic [1:0] r_hist [$];

  function automatic logic [7:0] byte_of(input int s, input int p);
    logic [31:0] sv, pv;
    sv = s;
    pv = p;
    return {sv[0], pv[6:0]};
  endfunction

  task automatic clear_hist();
    obs.delete();
    g_hist.delete();
    b_hist.delete();
    e_hist.delete();
    r_hist.delete();
    rdy_bad = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b1;
    in_vld = '0; in_sof = '0; in_eof = '0; in_data = '0; out_rdy = 1'b0; src_en = 2'b11;
    s_in_vld = '0; s_in_sof = '0; s_in_eof = '0; s_in_data = '0; s_out_rdy = 1'b0; s_src_en = 2'b11;
    for (int s = 0; s < 2; s++) begin
      ptr[s] = 0; frames_left[s] = 0; dup_sof_pos[s] = -1; len[s] = 1;
    end
    @(negedge clk);
    rest = 1'b0;
    clear_hist();
  endtask

  // One cycle of the source/sink model: drive at negedge, sample 1 ns later.
  task automatic step(input logic rdy_v);
    @(negedge clk);
    out_rdy = rdy_v;
    for (int s = 0; s < 2; s++) begin
      if (frames_left[s] > 0) begin
        in_vld[s] = 1'b1;
        in_sof[s] = (ptr[s] == 0) || (ptr[s] == dup_sof_pos[s]);
        in_eof[s] = (ptr[s] == len[s] - 1);
        in_data[8*s +: 8] = byte_of(s, ptr[s]);
      end else begin
        in_vld[s] = 1'b0; in_sof[s] = 1'b0; in_eof[s] = 1'b0;
        in_data[8*s +: 8] = '0;
      end
    end
    #1;
    if (out_vld && out_rdy) obs.push_back('{g_hist.size(), out_data, out_sof, out_eof});
    for (int s = 0; s < 2; s++) if (grant[s] && in_rdy[s] !== out_rdy) rdy_bad++;
    g_hist.push_back(grant);
    b_hist.push_back(busy);
    e_hist.push_back(err_pulse);
    r_hist.push_back(in_rdy);
    for (int s = 0; s < 2; s++) begin
      if (in_vld[s] && in_rdy[s]) begin
        if (ptr[s] == len[s] - 1) begin
          ptr[s] = 0;
          frames_left[s]--;
        end else begin
          ptr[s]++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rest = 1'b1;
    in_vld = '0; in_sof = '0; in_eof = '0; in_data = '0; out_rdy = 1'b0; src_en = 2'b11;
    #1;
    nvec++; if (grant !== 2'b00) begin nfail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++; if (out_vld !== 1'b0 || in_rdy !== 2'b00 || err_pulse !== 2'b00) begin
      nfail++; $display("FAIL reset_outs: out_vld=%b in_rdy=%b err=%b expected 0/00/00", out_vld, in_rdy, err_pulse);
    end
    nvec++; if (frm_cnt !== 32'h0) begin nfail++; $display("FAIL reset_cnt: got %h expected 00000000", frm_cnt); end
  endtask

  task automatic test_single_frame();
    int bad;
    do_reset();
    len[0] = 60; frames_left[0] = 1;
    repeat (80) step(1'b1);
    nvec++; if (g_hist[0] !== 2'b00) begin nfail++; $display("FAIL single_grant_c0: got %b expected 00", g_hist[0]); end
    nvec++; if (g_hist[1] !== 2'b01) begin nfail++; $display("FAIL single_grant_c1: got %b expected 01", g_hist[1]); end
    nvec++; if (g_hist[61] !== 2'b00) begin nfail++; $display("FAIL single_grant_drop: got %b expected 00", g_hist[61]); end
    nvec++; if (obs.size() != 60) begin nfail++; $display("FAIL single_beats: got %0d expected 60", obs.size()); end
    bad = 0;
    foreach (obs[k]) begin
      if (obs[k].cyc != 1 + k || obs[k].data !== byte_of(0, k) || obs[k].sof !== (k == 0) || obs[k].eof !== (k == 59)) bad++;
    end
    nvec++; if (bad != 0) begin nfail++; $display("FAIL single_seq: bad beats %0d expected 0", bad); end
    nvec++; if (b_hist[72] !== 1'b1) begin nfail++; $display("FAIL single_busy_gap_end: got %b expected 1", b_hist[72]); end
    nvec++; if (b_hist[73] !== 1'b0) begin nfail++; $display("FAIL single_busy_idle: got %b expected 0", b_hist[73]); end
    nvec++; if (frm_cnt !== 32'h0000_0001) begin nfail++; $display("FAIL single_cnt: got %h expected 00000001", frm_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    len[0] = 64; len[1] = 64; frames_left[0] = 2; frames_left[1] = 2;
    repeat (320) step(1'b1);
    nvec++; if (obs.size() != 256) begin nfail++; $display("FAIL b2b_beats: got %0d expected 256", obs.size()); end
    if (obs.size() == 256) begin
      nvec++; if (obs[0].cyc != 1) begin nfail++; $display("FAIL b2b_first: got cycle %0d expected 1", obs[0].cyc); end
      for (int f = 0; f < 4; f++) begin
        bad = 0;
        for (int k = 0; k < 64; k++) begin
          if (obs[64*f+k].data !== byte_of(f % 2, k) || obs[64*f+k].cyc != obs[64*f].cyc + k ||
              obs[64*f+k].sof !== (k == 0) || obs[64*f+k].eof !== (k == 63)) bad++;
        end
        nvec++; if (bad != 0) begin nfail++; $display("FAIL b2b_frame%0d: bad beats %0d expected 0", f, bad); end
      end
      for (int f = 1; f < 4; f++) begin
        nvec++;
        if (obs[64*f].cyc - obs[64*f-1].cyc != IFG + 2) begin
          nfail++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", f, obs[64*f].cyc - obs[64*f-1].cyc, IFG + 2);
        end
      end
    end
    nvec++; if (frm_cnt !== 32'h0002_0002) begin nfail++; $display("FAIL b2b_cnt: got %h expected 00020002", frm_cnt); end
  endtask

  task automatic test_rdy_toggle();
    int bad;
    do_reset();
    len[1] = 20; frames_left[1] = 1;
    for (int i = 0; i < 60; i++) step(i % 2 == 0);
    nvec++; if (obs.size() != 20) begin nfail++; $display("FAIL toggle_beats: got %0d expected 20", obs.size()); end
    bad = 0;
    foreach (obs[k]) begin
      if (obs[k].cyc != 2 + 2*k || obs[k].data !== byte_of(1, k) || obs[k].sof !== (k == 0) || obs[k].eof !== (k == 19)) bad++;
    end
    nvec++; if (bad != 0) begin nfail++; $display("FAIL toggle_seq: bad beats %0d expected 0", bad); end
    nvec++; if (rdy_bad != 0) begin nfail++; $display("FAIL toggle_rdy_mirror: bad cycles %0d expected 0", rdy_bad); end
    nvec++; if (frm_cnt !== 32'h0001_0000) begin nfail++; $display("FAIL toggle_cnt: got %h expected 00010000", frm_cnt); end
  endtask

  task automatic test_src_en();
    int bad;
    do_reset();
    src_en = 2'b01;
    len[0] = 8; len[1] = 8; frames_left[0] = 1; frames_left[1] = 1;
    repeat (40) step(1'b1);
    bad = 0;
    foreach (obs[k]) if (obs[k].data[7] !== 1'b0) bad++;
    nvec++; if (obs.size() != 8 || bad != 0) begin nfail++; $display("FAIL en_src0_only: beats %0d foreign %0d expected 8/0", obs.size(), bad); end
    bad = 0;
    foreach (r_hist[k]) if (r_hist[k][1] !== 1'b0 || g_hist[k][1] !== 1'b0 || e_hist[k] !== 2'b00) bad++;
    nvec++; if (bad != 0) begin nfail++; $display("FAIL en_src1_blocked: bad cycles %0d expected 0", bad); end
    nvec++; if (frames_left[1] != 1) begin nfail++; $display("FAIL en_src1_pending: got %0d expected 1", frames_left[1]); end
    src_en = 2'b11;
    clear_hist();
    repeat (20) step(1'b1);
    nvec++; if (g_hist[1] !== 2'b10) begin nfail++; $display("FAIL en_src1_grant: got %b expected 10", g_hist[1]); end
    bad = 0;
    foreach (obs[k]) if (obs[k].data !== byte_of(1, k)) bad++;
    nvec++; if (obs.size() != 8 || bad != 0) begin nfail++; $display("FAIL en_src1_frame: beats %0d bad %0d expected 8/0", obs.size(), bad); end
  endtask

  task automatic test_errors();
    int nerr;
    do_reset();
    @(negedge clk);
    out_rdy = 1'b1; in_vld = 2'b10; in_sof = 2'b00; in_eof = 2'b00; in_data = 16'hAA00;
    #1;
    nvec++; if (in_rdy !== 2'b10) begin nfail++; $display("FAIL orphan_rdy: got %b expected 10", in_rdy); end
    nvec++; if (out_vld !== 1'b0 || err_pulse !== 2'b00) begin nfail++; $display("FAIL orphan_same_cycle: vld=%b err=%b expected 0/00", out_vld, err_pulse); end
    @(negedge clk);
    in_vld = 2'b00; in_data = '0;
    #1;
    nvec++; if (err_pulse !== 2'b10) begin nfail++; $display("FAIL orphan_err: got %b expected 10", err_pulse); end
    nvec++; if (out_vld !== 1'b0 || grant !== 2'b00) begin nfail++; $display("FAIL orphan_nograin: vld=%b grant=%b expected 0/00", out_vld, grant); end
    @(negedge clk);
    #1;
    nvec++; if (err_pulse !== 2'b00) begin nfail++; $display("FAIL orphan_err_len: got %b expected 00", err_pulse); end
    clear_hist();
    len[0] = 10; dup_sof_pos[0] = 5; frames_left[0] = 1;
    repeat (30) step(1'b1);
    nvec++; if (obs.size() != 10) begin nfail++; $display("FAIL dupsof_beats: got %0d expected 10", obs.size()); end
    if (obs.size() == 10) begin
      nvec++;
      if (obs[0].sof !== 1'b1 || obs[5].sof !== 1'b0 || obs[5].data !== byte_of(0, 5)) begin
        nfail++; $display("FAIL dupsof_fwd: sof0=%b sof5=%b data5=%h expected 1/0/%h", obs[0].sof, obs[5].sof, obs[5].data, byte_of(0, 5));
      end
    end
    nerr = 0;
    foreach (e_hist[k]) if (e_hist[k] !== 2'b00) nerr++;
    nvec++; if (e_hist[7] !== 2'b01 || nerr != 1) begin nfail++; $display("FAIL dupsof_err: c7=%b pulses=%0d expected 01/1", e_hist[7], nerr); end
    nvec++; if (frm_cnt !== 32'h0000_0001) begin nfail++; $display("FAIL dupsof_cnt: got %h expected 00000001", frm_cnt); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    len[0] = 40; frames_left[0] = 1;
    for (int i = 0; i < 60 && obs.size() < 20; i++) step(1'b1);
    nvec++; if (obs.size() != 20) begin nfail++; $display("FAIL midrst_progress: got %0d expected 20", obs.size()); end
    @(negedge clk);
    rest = 1'b1;
    #1;
    nvec++; if (grant !== 2'b00 || out_vld !== 1'b0) begin nfail++; $display("FAIL midrst_async: grant=%b vld=%b expected 00/0", grant, out_vld); end
    nvec++; if (busy !== 1'b0 || in_rdy !== 2'b00) begin nfail++; $display("FAIL midrst_idle: busy=%b in_rdy=%b expected 0/00", busy, in_rdy); end
    in_vld = '0; in_sof = '0; in_eof = '0; in_data = '0;
    frames_left[0] = 0; ptr[0] = 0;
    @(negedge clk);
    rest = 1'b0;
    clear_hist();
    len[1] = 5; frames_left[1] = 1;
    repeat (25) step(1'b1);
    nvec++; if (g_hist[1] !== 2'b10) begin nfail++; $display("FAIL midrst_regrant: got %b expected 10", g_hist[1]); end
    nvec++; if (obs.size() != 5) begin nfail++; $display("FAIL midrst_frame: got %0d expected 5", obs.size()); end
    nvec++; if (frm_cnt !== 32'h0001_0000) begin nfail++; $display("FAIL midrst_cnt: got %h expected 00010000", frm_cnt); end
  endtask

  task automatic test_saturation();
    int beats;
    int flag_bad;
    do_reset();
    @(negedge clk);
    s_out_rdy = 1'b1; s_in_vld = 2'b10; s_in_sof = 2'b10; s_in_eof = 2'b10; s_in_data = 16'h5A00;
    beats = 0; flag_bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_out_vld && s_out_rdy) begin
        beats++;
        if (s_out_sof !== 1'b1 || s_out_eof !== 1'b1 || s_out_data !== 8'h5A || (i % 2) != 1) flag_bad++;
      end
      if (i == 1) begin
        nvec++; if (s_grant !== 2'b10) begin nfail++; $display("FAIL sat_grant: got %b expected 10", s_grant); end
      end
      if (i == 12) begin
        nvec++; if (s_frm_cnt[5:3] !== 3'd6) begin nfail++; $display("FAIL sat_cnt_6: got %0d expected 6", s_frm_cnt[5:3]); end
      end
      if (i == 14) begin
        nvec++; if (s_frm_cnt[5:3] !== 3'd7) begin nfail++; $display("FAIL sat_cnt_7: got %0d expected 7", s_frm_cnt[5:3]); end
      end
      @(negedge clk);
    end
    s_in_vld = '0; s_in_sof = '0; s_in_eof = '0;
    nvec++; if (beats != 10 || flag_bad != 0) begin nfail++; $display("FAIL sat_zero_gap: beats %0d bad %0d expected 10/0", beats, flag_bad); end
    nvec++; if (s_frm_cnt !== 6'b111_000) begin nfail++; $display("FAIL sat_hold: got %b expected 111000", s_frm_cnt); end
    nvec++; if (s_err_pulse !== 2'b00) begin nfail++; $display("FAIL sat_err: got %b expected 00", s_err_pulse); end
  endtask

  initial begin
    rest = 1'b1;
    in_vld = '0; in_sof = '0; in_eof = '0; in_data = '0; out_rdy = 1'b0; src_en = 2'b11;
    s_in_vld = '0; s_in_sof = '0; s_in_eof = '0; s_in_data = '0; s_out_rdy = 1'b0; s_src_en = 2'b11;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_rdy_toggle();
    test_src_en();
    test_errors();
    test_reset_midframe();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
